// File: rtl/pipeline_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_prefetch_pkg
// Shared definitions for the instruction-fetch front end: FSM state encoding,
// opcode field width, default HALT opcode and the fetch stride.
// -----------------------------------------------------------------------------
package pipeline_prefetch_pkg;

  // Front-end control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Opcode occupies the top OPCODE_W bits of an instruction word.
  localparam int OPCODE_W = 6;

  // Opcode that terminates the program.
  localparam logic [OPCODE_W-1:0] HALT_OP_DEFAULT = 6'h3F;

  // Byte stride between consecutive instruction words.
  localparam int PC_STEP = 4;

endpackage : pipeline_prefetch_pkg

// File: rtl/pipeline_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// pipeline_prefetch_fifo
// Synchronous FIFO used as the prefetch queue. Flush empties it in one edge
// and takes priority over push/pop. Simultaneous push and pop keep the count.
//
// Ports
//   clk      in   clock
//   reset    in   asynchronous active-high reset (control state only)
//   i_flush  in   drop all entries
//   i_push   in   write i_data at the tail
//   i_data   in   WIDTH-bit entry
//   i_pop    in   advance the head
//   o_data   out  head entry (valid when o_empty = 0)
//   o_count  out  number of stored entries (0..DEPTH)
//   o_full   out  count == DEPTH
//   o_empty  out  count == 0
// -----------------------------------------------------------------------------
module pipeline_prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule : pipeline_prefetch_fifo

// File: rtl/pipeline_prefetch.sv
// -----------------------------------------------------------------------------
// pipeline_prefetch
// Instruction-fetch front end. Issues reads to a 1-cycle-latency instruction
// memory, buffers {instr, pc+4} in a DEPTH-entry queue and hands the head to
// decode over a valid/ready handshake. Handles start, redirect and HALT.
//
// Ports
//   clk            in   clock
//   reset          in   asynchronous active-high reset
//   start          in   load start_addr, flush, begin fetching
//   start_addr     in   program start address (low 2 bits ignored)
//   redirect       in   taken branch/jump from ID
//   redirect_addr  in   redirect target (low 2 bits ignored)
//   imem_rd_en     out  read request this cycle
//   imem_addr      out  request address
//   imem_rdata     in   data for the request issued one cycle earlier
//   id_valid       out  queue head valid
//   id_instr       out  queue head instruction
//   id_pc_plus4    out  queue head PC+4
//   id_ready       in   decode accepts head
//   halted         out  HALT fetched; fetching stopped
//   busy           out  fetching (RUN state)
// -----------------------------------------------------------------------------
module pipeline_prefetch
  import pipeline_prefetch_pkg::*;
#(
  parameter int                    ADDR_W   = 32,
  parameter int                    INSTR_W  = 32,
  parameter int                    DEPTH    = 4,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter logic [OPCODE_W-1:0]   HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc_plus4,
  input  logic               id_ready,
  output logic               halted,
  output logic               busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = INSTR_W + ADDR_W;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   r_req_addr;
  logic                r_inflight;
  logic                r_drop;
  logic [INSTR_W-1:0]  r_hold_instr;
  logic [ADDR_W-1:0]   r_hold_pc4;

  logic                w_redir_ok;
  logic                w_flush;
  logic [ADDR_W-1:0]   w_new_pc;
  logic                w_resp;
  logic                w_halt_hit;
  logic [CW:0]         w_used;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic [QW-1:0]       w_q_in;
  logic [QW-1:0]       w_q_out;
  logic [CW-1:0]       w_count;
  logic                w_full;
  logic                w_empty;

  // Redirect only has meaning once fetching has begun.
  assign w_redir_ok = redirect && (r_state != ST_IDLE);
  assign w_flush    = start || w_redir_ok;

  // start wins over redirect; targets are forced word aligned.
  assign w_new_pc = start ? (start_addr    & ~ADDR_W'(3))
                          : (redirect_addr & ~ADDR_W'(3));

  // A response is usable unless it was marked dropped or a flush lands now.
  assign w_resp     = r_inflight && !r_drop && !w_flush;
  assign w_halt_hit = w_resp && (r_state == ST_RUN) &&
                      (imem_rdata[INSTR_W-1 -: OPCODE_W] == HALT_OP);

  // Credit: queued entries plus the outstanding request must fit in the queue.
  assign w_used  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue = (r_state == ST_RUN) && !w_flush &&
                   (w_used < (CW+1)'(DEPTH));

  assign w_push = w_resp && !w_full;
  assign w_pop  = !w_empty && id_ready && !w_flush;
  assign w_q_in = {imem_rdata, r_req_addr + ADDR_W'(PC_STEP)};

  pipeline_prefetch_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (w_q_in),
    .i_pop   (w_pop),
    .o_data  (w_q_out),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Control FSM, fetch PC and in-flight tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
    end else if (w_flush) begin
      // Nothing issues in a flush cycle, so no response follows it.
      r_state    <= ST_RUN;
      r_fetch_pc <= w_new_pc;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      // The request issued alongside the HALT response is past the program end.
      r_drop     <= w_issue && w_halt_hit;
      if (w_issue)    r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
      if (w_halt_hit) r_state    <= ST_HALTED;
    end
  end

  // Address of the outstanding request, used to form PC+4 on its response.
  always_ff @(posedge clk) begin
    if (w_issue) r_req_addr <= r_fetch_pc;
  end

  // Keep the last head visible while the queue is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_instr <= '0;
      r_hold_pc4   <= '0;
    end else if (!w_empty) begin
      r_hold_instr <= w_q_out[QW-1 -: INSTR_W];
      r_hold_pc4   <= w_q_out[ADDR_W-1:0];
    end
  end

  assign imem_rd_en  = w_issue;
  assign imem_addr   = r_fetch_pc;
  assign id_valid    = !w_empty;
  assign id_instr    = w_empty ? r_hold_instr : w_q_out[QW-1 -: INSTR_W];
  assign id_pc_plus4 = w_empty ? r_hold_pc4   : w_q_out[ADDR_W-1:0];
  assign halted      = (r_state == ST_HALTED);
  assign busy        = (r_state == ST_RUN);

endmodule : pipeline_prefetch

// File: tb/tb_pipeline_prefetch.sv
// -----------------------------------------------------------------------------
// tb_pipeline_prefetch
// Scoreboard bench for pipeline_prefetch: a behavioural 1-cycle instruction
// memory, an expected-delivery queue loaded on every start/redirect, a
// negedge monitor that pops and compares each decode handshake, and directed
// cycle-level checks of the request stream, reset, HALT and redirect.
// -----------------------------------------------------------------------------
module tb_pipeline_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] start_addr;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_ready;
  logic        halted;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_issue = 0;
  int          base;
  logic [31:0] halt_addr;
  logic [63:0] exp_q [$];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_flush = 1'b0;
  logic [63:0] prev_head  = '0;
  logic [63:0] e;

  pipeline_prefetch dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_addr    (start_addr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc_plus4   (id_pc_plus4),
    .id_ready      (id_ready),
    .halted        (halted),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Program image: opcode 0x01 everywhere except the configured HALT address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return {6'h3F, a[25:0]};
    return {6'h01, a[25:0]};
  endfunction

  // Expected delivery order from a new fetch target, up to and including HALT.
  task automatic load_exp(input logic [31:0] target);
    logic [31:0] a;
    exp_q.delete();
    a = target;
    for (int i = 0; i < 48; i++) begin
      exp_q.push_back({mem_word(a), a + 32'd4});
      if (a == halt_addr) break;
      a = a + 32'd4;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory with one cycle of read latency.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem_word(imem_addr);
  end

  // Handshake monitor: scoreboard pops and head stability under stall.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (imem_rd_en) n_issue++;
      if (prev_valid && !prev_ready && !prev_flush) begin
        chk("stall_valid", 64'(id_valid), 64'd1);
        chk("stall_head", {id_instr, id_pc_plus4}, prev_head);
      end
      if (id_valid && id_ready && !start && !redirect) begin
        chk("sb_avail", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_head", {id_instr, id_pc_plus4}, e);
        end
      end
      prev_valid = id_valid;
      prev_ready = id_ready;
      prev_flush = start | redirect;
      prev_head  = {id_instr, id_pc_plus4};
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; start_addr = '0; redirect = 1'b0;
    redirect_addr = '0; id_ready = 1'b0; halt_addr = '1;
    repeat (3) cyc();
    #2;
    chk("rst_rd_en",  64'(imem_rd_en),  64'd0);
    chk("rst_addr",   64'(imem_addr),   64'd0);
    chk("rst_valid",  64'(id_valid),    64'd0);
    chk("rst_instr",  64'(id_instr),    64'd0);
    chk("rst_pc4",    64'(id_pc_plus4), 64'd0);
    chk("rst_halted", 64'(halted),      64'd0);
    chk("rst_busy",   64'(busy),        64'd0);
    cyc(); reset = 1'b0;

    // Redirect while idle is ignored.
    cyc(); redirect = 1'b1; redirect_addr = 32'h400; #2;
    chk("idle_redir_rd", 64'(imem_rd_en), 64'd0);
    cyc(); redirect = 1'b0; #2;
    chk("idle_redir_rd2",   64'(imem_rd_en), 64'd0);
    chk("idle_redir_busy",  64'(busy),       64'd0);
    chk("idle_redir_addr",  64'(imem_addr),  64'd0);

    // Streaming from 0x100 with decode always ready.
    cyc(); start = 1'b1; start_addr = 32'h100; id_ready = 1'b1; load_exp(32'h100); #2;
    chk("t2_rd_c0", 64'(imem_rd_en), 64'd0);
    cyc(); start = 1'b0; #2;
    chk("t2_rd_c1",   64'(imem_rd_en), 64'd1);
    chk("t2_addr_c1", 64'(imem_addr),  64'h100);
    chk("t2_busy",    64'(busy),       64'd1);
    chk("t2_valid_c1", 64'(id_valid),  64'd0);
    cyc(); #2;
    chk("t2_addr_c2",  64'(imem_addr), 64'h104);
    chk("t2_valid_c2", 64'(id_valid),  64'd0);
    cyc(); #2;
    chk("t2_addr_c3",  64'(imem_addr),   64'h108);
    chk("t2_valid_c3", 64'(id_valid),    64'd1);
    chk("t2_pc4_c3",   64'(id_pc_plus4), 64'h104);
    cyc(); #2;
    chk("t2_addr_c4", 64'(imem_addr),   64'h10C);
    chk("t2_pc4_c4",  64'(id_pc_plus4), 64'h108);
    repeat (6) cyc();

    // Decode stalled: exactly DEPTH requests, then one per freed credit.
    start = 1'b1; start_addr = 32'h100; id_ready = 1'b0; load_exp(32'h100);
    cyc(); start = 1'b0; base = n_issue;
    repeat (8) cyc();
    #2;
    chk("t3_issued",  64'(n_issue - base), 64'd4);
    chk("t3_rd_idle", 64'(imem_rd_en),     64'd0);
    chk("t3_pc4",     64'(id_pc_plus4),    64'h104);
    id_ready = 1'b1;
    cyc(); id_ready = 1'b0; base = n_issue;
    repeat (5) cyc();
    #2;
    chk("t3_credit",   64'(n_issue - base), 64'd1);
    chk("t3_pc4_next", 64'(id_pc_plus4),    64'h108);

    // Redirect with three queued and one in flight.
    cyc(); start = 1'b1; start_addr = 32'h100; load_exp(32'h100);
    cyc(); start = 1'b0;
    repeat (4) cyc();
    redirect = 1'b1; redirect_addr = 32'h200; id_ready = 1'b1; load_exp(32'h200); #2;
    chk("t4_valid_pre", 64'(id_valid),   64'd1);
    chk("t4_rd_pre",    64'(imem_rd_en), 64'd0);
    cyc(); redirect = 1'b0; #2;
    chk("t4_flushed", 64'(id_valid),   64'd0);
    chk("t4_rd",      64'(imem_rd_en), 64'd1);
    chk("t4_addr",    64'(imem_addr),  64'h200);
    cyc(); cyc(); #2;
    chk("t4_first_pc4", 64'(id_pc_plus4), 64'h204);
    repeat (4) cyc();

    // Reset while running with three entries queued.
    id_ready = 1'b0;
    cyc(); start = 1'b1; start_addr = 32'h100; load_exp(32'h100);
    cyc(); start = 1'b0;
    repeat (4) cyc();
    #2;
    chk("t1_valid_pre", 64'(id_valid), 64'd1);
    reset = 1'b1; exp_q.delete(); #1;
    chk("t1_valid", 64'(id_valid),   64'd0);
    chk("t1_rd",    64'(imem_rd_en), 64'd0);
    chk("t1_addr",  64'(imem_addr),  64'd0);
    chk("t1_busy",  64'(busy),       64'd0);
    cyc(); #2;
    chk("t1_valid_nc", 64'(id_valid), 64'd0);
    chk("t1_busy_nc",  64'(busy),     64'd0);
    reset = 1'b0;

    // HALT at 0x10C; then redirect to 0x300 resumes.
    halt_addr = 32'h10C;
    cyc(); start = 1'b1; start_addr = 32'h100; id_ready = 1'b1; load_exp(32'h100);
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    cyc(); #2;
    chk("t5_rd_drop",   64'(imem_rd_en), 64'd1);
    chk("t5_addr_drop", 64'(imem_addr),  64'h110);
    chk("t5_halt_pre",  64'(halted),     64'd0);
    cyc(); #2;
    chk("t5_halted",    64'(halted),      64'd1);
    chk("t5_halt_pc4",  64'(id_pc_plus4), 64'h110);
    chk("t5_halt_op",   64'(id_instr[31:26]), 64'h3F);
    chk("t5_rd_off",    64'(imem_rd_en),  64'd0);
    chk("t5_busy",      64'(busy),        64'd0);
    repeat (4) cyc();
    #2;
    chk("t5_drained", 64'(exp_q.size()), 64'd0);
    chk("t5_empty",   64'(id_valid),     64'd0);
    chk("t5_rd_held", 64'(imem_rd_en),   64'd0);
    halt_addr = '1;
    cyc(); redirect = 1'b1; redirect_addr = 32'h300; load_exp(32'h300); #2;
    chk("t5_still_halted", 64'(halted), 64'd1);
    cyc(); redirect = 1'b0; #2;
    chk("t5_resume_halted", 64'(halted),     64'd0);
    chk("t5_resume_busy",   64'(busy),       64'd1);
    chk("t5_resume_addr",   64'(imem_addr),  64'h300);
    chk("t5_resume_rd",     64'(imem_rd_en), 64'd1);
    repeat (6) cyc();

    // start and redirect together: start wins, low address bits cleared.
    start = 1'b1; start_addr = 32'h502; redirect = 1'b1; redirect_addr = 32'h600;
    load_exp(32'h500);
    cyc(); start = 1'b0; redirect = 1'b0; #2;
    chk("t6_addr", 64'(imem_addr),  64'h500);
    chk("t6_rd",   64'(imem_rd_en), 64'd1);
    repeat (6) cyc();

    // PC wraps modulo 2^32.
    start = 1'b1; start_addr = 32'hFFFF_FFF8; load_exp(32'hFFFF_FFF8);
    cyc(); start = 1'b0; #2;
    chk("wrap_addr0", 64'(imem_addr), 64'hFFFF_FFF8);
    cyc(); cyc(); #2;
    chk("wrap_addr2", 64'(imem_addr), 64'h0);
    repeat (6) cyc();

    id_ready = 1'b0;
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipeline_prefetch
